// File: rtl/jk_mod_counter.sv
// ----------------------------------------------------------------------------
// jk_mod_counter
// 4-bit programmable-modulus up/down counter with synchronous load.
// Besides the registered count it exposes the J/K excitation that a bank of
// four external JK flip-flops would need in order to follow the same sequence.
// Any wrap produces a one-cycle terminal-count pulse (oTc) and sets a sticky
// overflow flag (oOvf). A load clears that flag.
// ----------------------------------------------------------------------------
module jk_mod_counter (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEn,
    input  logic       iUp,
    input  logic       iLoad,
    input  logic [3:0] iData,
    input  logic [3:0] iMod,
    output logic [3:0] oQ,
    output logic [3:0] oJ,
    output logic [3:0] oK,
    output logic       oTc,
    output logic       oOvf
);

    // Operation chosen for the coming edge, in priority order: load, count, hold.
    typedef enum logic [1:0] {
        OpHold = 2'd0,
        OpLoad = 2'd1,
        OpUp   = 2'd2,
        OpDown = 2'd3
    } opSel_t;

    opSel_t     opSel;
    logic [3:0] topValue;   // M-1, the largest legal count
    logic [3:0] loadValue;  // iData clamped into 0..M-1
    logic [3:0] nextQ;      // count after the coming edge
    logic       wrapNext;   // the coming edge is a wrap

    // iMod = 0 stands for a modulus of 16. Subtracting one in 4-bit arithmetic
    // maps 0 to 15, so the top value needs no special case.
    assign topValue  = iMod - 4'd1;

    // "iData < M" is the same test as "iData <= M-1".
    assign loadValue = (iData <= topValue) ? iData : topValue;

    // Decode the strobes into a single operation.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the block can leave it unassigned and
        // infer a latch.
        opSel = OpHold;
        if (iLoad) begin
            opSel = OpLoad;
        end else if (iEn) begin
            opSel = iUp ? OpUp : OpDown;
        end
    end

    // Next count and wrap detection for the decoded operation.
    always_comb begin
        nextQ    = oQ;
        wrapNext = 1'b0;
        unique case (opSel)
            OpLoad: begin
                nextQ = loadValue;
            end
            OpUp: begin
                // ">=" rather than "==" so a count left above the top by a
                // modulus shrink also wraps to zero and reports a wrap.
                if (oQ >= topValue) begin
                    nextQ    = 4'd0;
                    wrapNext = 1'b1;
                end else begin
                    nextQ = oQ + 4'd1;
                end
            end
            OpDown: begin
                if (oQ == 4'd0) begin
                    nextQ    = topValue;
                    wrapNext = 1'b1;
                end else if (oQ > topValue) begin
                    // Out of range after a modulus shrink: pull back to the
                    // top without calling it a wrap.
                    nextQ = topValue;
                end else begin
                    nextQ = oQ - 4'd1;
                end
            end
            default: begin
                nextQ    = oQ;
                wrapNext = 1'b0;
            end
        endcase
    end

    // JK excitation: set bits going 0->1, clear bits going 1->0, never toggle.
    always_comb begin
        oJ = 4'b0000;
        oK = 4'b0000;
        // While reset is asserted the external flops are held at zero as
        // well, so no excitation is presented to them.
        if (iRst_n) begin
            oJ = ~oQ &  nextQ;
            oK =  oQ & ~nextQ;
        end
    end

    // Count, terminal-count pulse and sticky overflow registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oQ   <= 4'd0;
            oTc  <= 1'b0;
            oOvf <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the values from before the edge, regardless of
            // statement order.
            oQ  <= nextQ;
            oTc <= wrapNext;
            if (opSel == OpLoad) begin
                oOvf <= 1'b0;
            end else if (wrapNext) begin
                oOvf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_jk_mod_counter
// Directed scenarios followed by a randomized run. A behavioural model of the
// counter rules (plain integer arithmetic) predicts every output, and a model
// of four JK flip-flops fed from oJ/oK must track oQ.
// ----------------------------------------------------------------------------
module tb_jk_mod_counter;

    logic       iClk;
    logic       iRst_n;
    logic       iEn;
    logic       iUp;
    logic       iLoad;
    logic [3:0] iData;
    logic [3:0] iMod;
    logic [3:0] oQ;
    logic [3:0] oJ;
    logic [3:0] oK;
    logic       oTc;
    logic       oOvf;

    jk_mod_counter dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iEn    (iEn),
        .iUp    (iUp),
        .iLoad  (iLoad),
        .iData  (iData),
        .iMod   (iMod),
        .oQ     (oQ),
        .oJ     (oJ),
        .oK     (oK),
        .oTc    (oTc),
        .oOvf   (oOvf)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state and prediction for the coming edge.
    int         mQ;
    int         mTc;
    int         mOvf;
    int         nQ;
    int         nTc;
    int         nOvf;
    logic [3:0] jkQ;    // four external JK flops driven by oJ/oK

    int upSeq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Counter rules written directly in terms of the modulus.
    task automatic predict();
        int m;
        m = (iMod == 4'd0) ? 16 : int'(iMod);
        nQ   = mQ;
        nTc  = 0;
        nOvf = mOvf;
        if (iLoad) begin
            nQ   = (int'(iData) < m) ? int'(iData) : m - 1;
            nOvf = 0;
        end else if (iEn && iUp) begin
            if (mQ + 1 >= m) begin
                nQ = 0; nTc = 1; nOvf = 1;
            end else begin
                nQ = mQ + 1;
            end
        end else if (iEn) begin
            if (mQ == 0) begin
                nQ = m - 1; nTc = 1; nOvf = 1;
            end else if (mQ >= m) begin
                nQ = m - 1;
            end else begin
                nQ = mQ - 1;
            end
        end
    endtask

    task automatic modelReset();
        mQ = 0; mTc = 0; mOvf = 0; jkQ = 4'd0;
    endtask

    // One clock: check excitation before the edge, registers after it.
    task automatic cycle(input string tag);
        int         expJ;
        int         expK;
        logic [3:0] jkNext;
        #1;
        predict();
        expJ = ~mQ & nQ & 15;
        expK = mQ & ~nQ & 15;
        check({tag, ".j"}, 32'(oJ), expJ);
        check({tag, ".k"}, 32'(oK), expK);
        check({tag, ".toggle"}, 32'(oJ & oK), 0);
        for (int i = 0; i < 4; i++) begin
            case ({oJ[i], oK[i]})
                2'b10:   jkNext[i] = 1'b1;
                2'b01:   jkNext[i] = 1'b0;
                2'b11:   jkNext[i] = ~jkQ[i];
                default: jkNext[i] = jkQ[i];
            endcase
        end
        @(posedge iClk);
        #1;
        mQ = nQ; mTc = nTc; mOvf = nOvf; jkQ = jkNext;
        check({tag, ".q"},   32'(oQ),   mQ);
        check({tag, ".tc"},  32'(oTc),  mTc);
        check({tag, ".ovf"}, 32'(oOvf), mOvf);
        check({tag, ".jkflops"}, 32'(jkQ), 32'(oQ));
    endtask

    initial begin
        // Reset with inputs that would otherwise count down to 9.
        iRst_n = 1'b0; iEn = 1'b1; iUp = 1'b0; iLoad = 1'b0;
        iData = 4'd0; iMod = 4'd10;
        modelReset();
        #12;
        check("rst.q",   32'(oQ),   0);
        check("rst.tc",  32'(oTc),  0);
        check("rst.ovf", 32'(oOvf), 0);
        check("rst.j",   32'(oJ),   0);
        check("rst.k",   32'(oK),   0);

        // Up count M = 10 from reset for 12 clocks.
        iRst_n = 1'b1; iUp = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle("up10");
            check("up10.seq", 32'(oQ),   upSeq[i]);
            check("up10.tc",  32'(oTc),  (i == 9) ? 1 : 0);
            check("up10.ovf", 32'(oOvf), (i >= 9) ? 1 : 0);
        end

        // Down count M = 16 from Q = 0.
        iMod = 4'd0; iLoad = 1'b1; iData = 4'd0;
        cycle("ld0");
        iLoad = 1'b0; iUp = 1'b0;
        cycle("dn16");
        check("dn16.wrapq",  32'(oQ),  15);
        check("dn16.wraptc", 32'(oTc), 1);
        #1;
        check("dn16.j15", 32'(oJ), 0);
        check("dn16.k15", 32'(oK), 1);
        cycle("dn16b");
        check("dn16.q14", 32'(oQ),  14);
        check("dn16.tc0", 32'(oTc), 0);

        // Load clamp and load priority over count (overflow is set here).
        iMod = 4'd10; iLoad = 1'b1; iData = 4'd12; iEn = 1'b0;
        cycle("ldclamp");
        check("ldclamp.q",   32'(oQ),   9);
        check("ldclamp.ovf", 32'(oOvf), 0);
        iEn = 1'b1; iUp = 1'b1; iData = 4'd3;
        cycle("ldprio");
        check("ldprio.q",  32'(oQ),  3);
        check("ldprio.tc", 32'(oTc), 0);

        // Modulus shrink with Q = 8, then step up and down.
        iMod = 4'd0; iLoad = 1'b1; iData = 4'd8; iEn = 1'b0;
        cycle("ld8a");
        iLoad = 1'b0; iMod = 4'd5; iEn = 1'b1; iUp = 1'b1;
        cycle("shrinkup");
        check("shrinkup.q",  32'(oQ),  0);
        check("shrinkup.tc", 32'(oTc), 1);
        iMod = 4'd0; iLoad = 1'b1; iData = 4'd8; iEn = 1'b0;
        cycle("ld8b");
        iLoad = 1'b0; iMod = 4'd5; iEn = 1'b1; iUp = 1'b0;
        cycle("shrinkdn");
        check("shrinkdn.q",  32'(oQ),  4);
        check("shrinkdn.tc", 32'(oTc), 0);

        // Asynchronous reset between edges at Q = 7, mid-count.
        iMod = 4'd0; iLoad = 1'b1; iData = 4'd7; iEn = 1'b0;
        cycle("ld7");
        iLoad = 1'b0; iEn = 1'b1; iUp = 1'b1;
        #2;
        iRst_n = 1'b0;
        #1;
        check("arst.q",   32'(oQ),   0);
        check("arst.tc",  32'(oTc),  0);
        check("arst.ovf", 32'(oOvf), 0);
        check("arst.j",   32'(oJ),   0);
        check("arst.k",   32'(oK),   0);
        modelReset();
        @(negedge iClk);
        iRst_n = 1'b1; iEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("relhold");
            check("relhold.q", 32'(oQ), 0);
        end

        // Randomized run checked against the model and the JK flop bank.
        for (int i = 0; i < 1000; i++) begin
            iEn   = ($urandom_range(0, 3) != 0);
            iUp   = 1'($urandom_range(0, 1));
            iLoad = ($urandom_range(0, 15) == 0);
            iData = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) iMod = 4'($urandom_range(0, 15));
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
